// File: rtl/binary2bcd_double_dabble.sv
// 8-bit binary to BCD converter built on shift-and-add-3 (double dabble).
// The digits are computed combinationally and registered once, so results appear one cycle after the input.
module binary2bcd_double_dabble (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_binary,
  output logic [7:0]  packed_bcd,
  output logic [15:0] unpacked_bcd,
  output logic [3:0]  hundreds_bcd
);

  // Returns {H, T, O}. Each digit is corrected before it is shifted, so no digit can exceed 9.
  function automatic logic [11:0] f_double_dabble(input logic [7:0] bin);
    logic [19:0] scratch;
    scratch = {12'h000, bin};
    for (int i = 0; i < 8; i++) begin
      if (scratch[19:16] >= 4'd5) begin
        scratch[19:16] = scratch[19:16] + 4'd3;
      end else begin
        scratch[19:16] = scratch[19:16];
      end
      if (scratch[15:12] >= 4'd5) begin
        scratch[15:12] = scratch[15:12] + 4'd3;
      end else begin
        scratch[15:12] = scratch[15:12];
      end
      if (scratch[11:8] >= 4'd5) begin
        scratch[11:8] = scratch[11:8] + 4'd3;
      end else begin
        scratch[11:8] = scratch[11:8];
      end
      scratch = {scratch[18:0], 1'b0};
    end
    return scratch[19:8];
  endfunction

  logic [11:0] w_digits;
  logic [3:0]  w_hundreds;
  logic [3:0]  w_tens;
  logic [3:0]  w_ones;

  assign w_digits   = f_double_dabble(in_binary);
  assign w_hundreds = w_digits[11:8];
  assign w_tens     = w_digits[7:4];
  assign w_ones     = w_digits[3:0];

  // Output register: takes a new conversion on every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      packed_bcd   <= 8'h00;
      unpacked_bcd <= 16'h0000;
      hundreds_bcd <= 4'h0;
    end else begin
      packed_bcd   <= {w_tens, w_ones};
      unpacked_bcd <= {4'h0, w_tens, 4'h0, w_ones};
      hundreds_bcd <= w_hundreds;
    end
  end

endmodule

// File: tb/tb_binary2bcd_double_dabble.sv
// Self-checking bench for binary2bcd_double_dabble. It uses a table of fixed vectors, handwritten sequences,
// an exhaustive sweep and random values, all checked against an arithmetic reference model.
module tb_binary2bcd_double_dabble;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_binary;
  logic [7:0]  packed_bcd;
  logic [15:0] unpacked_bcd;
  logic [3:0]  hundreds_bcd;

  int n_cmp;
  int n_fail;

  binary2bcd_double_dabble dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_binary    (in_binary),
    .packed_bcd   (packed_bcd),
    .unpacked_bcd (unpacked_bcd),
    .hundreds_bcd (hundreds_bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  in_val;
    logic [7:0]  exp_packed;
    logic [15:0] exp_unpacked;
    logic [3:0]  exp_hundreds;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // The reference model works in decimal arithmetic and does not use shifting.
  function automatic logic [7:0] ref_packed(input int v);
    int t;
    int o;
    t = (v / 10) % 10;
    o = v % 10;
    return {t[3:0], o[3:0]};
  endfunction

  function automatic logic [15:0] ref_unpacked(input int v);
    int t;
    int o;
    t = (v / 10) % 10;
    o = v % 10;
    return {4'h0, t[3:0], 4'h0, o[3:0]};
  endfunction

  function automatic logic [3:0] ref_hundreds(input int v);
    int h;
    h = v / 100;
    return h[3:0];
  endfunction

  task automatic check_all(input string name, input int v);
    chk({name, ".packed"},   {24'h0, packed_bcd},   {24'h0, ref_packed(v)});
    chk({name, ".unpacked"}, {16'h0, unpacked_bcd}, {16'h0, ref_unpacked(v)});
    chk({name, ".hundreds"}, {28'h0, hundreds_bcd}, {28'h0, ref_hundreds(v)});
  endtask

  initial begin
    int sum;
    int r;
    n_cmp  = 0;
    n_fail = 0;

    vecs[0] = '{8'd0,   8'h00, 16'h0000, 4'd0};
    vecs[1] = '{8'd9,   8'h09, 16'h0009, 4'd0};
    vecs[2] = '{8'd10,  8'h10, 16'h0100, 4'd0};
    vecs[3] = '{8'd19,  8'h19, 16'h0109, 4'd0};
    vecs[4] = '{8'd99,  8'h99, 16'h0909, 4'd0};
    vecs[5] = '{8'd100, 8'h00, 16'h0000, 4'd1};
    vecs[6] = '{8'd199, 8'h99, 16'h0909, 4'd1};
    vecs[7] = '{8'd255, 8'h55, 16'h0505, 4'd2};

    // Reset is held while the clock toggles, so the outputs must stay at zero.
    rst_n     = 1'b0;
    in_binary = 8'd57;
    repeat (3) begin
      @(negedge clk);
      chk("reset.packed",   {24'h0, packed_bcd},   32'h0);
      chk("reset.unpacked", {16'h0, unpacked_bcd}, 32'h0);
      chk("reset.hundreds", {28'h0, hundreds_bcd}, 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_release.packed", {24'h0, packed_bcd}, 32'h57);

    // Sweep 0..99: each value is applied on one falling edge and checked on the next.
    for (int i = 0; i < 100; i++) begin
      in_binary = i[7:0];
      @(negedge clk);
      chk("sweep.packed", {24'h0, packed_bcd}, {24'h0, ref_packed(i)});
    end

    // Table of boundary vectors.
    for (int i = 0; i < 8; i++) begin
      in_binary = vecs[i].in_val;
      @(negedge clk);
      chk("table.packed",   {24'h0, packed_bcd},   {24'h0, vecs[i].exp_packed});
      chk("table.unpacked", {16'h0, unpacked_bcd}, {16'h0, vecs[i].exp_unpacked});
      chk("table.hundreds", {28'h0, hundreds_bcd}, {28'h0, vecs[i].exp_hundreds});
    end

    // Latency: the output must not follow the input until a rising edge has occurred.
    in_binary = 8'd42;
    #1;
    chk("latency.hold", {24'h0, packed_bcd}, 32'h55);
    @(negedge clk);
    chk("latency.first", {24'h0, packed_bcd}, 32'h42);
    in_binary = 8'd7;
    #1;
    chk("latency.hold2", {24'h0, packed_bcd}, 32'h42);
    @(negedge clk);
    chk("latency.second", {24'h0, packed_bcd}, 32'h07);

    // Reset asserted in mid-cycle must clear the outputs immediately.
    in_binary = 8'd255;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset.packed",   {24'h0, packed_bcd},   32'h0);
    chk("midreset.unpacked", {16'h0, unpacked_bcd}, 32'h0);
    chk("midreset.hundreds", {28'h0, hundreds_bcd}, 32'h0);
    in_binary = 8'd123;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("midreset_release", 123);

    // Exhaustive check: the digits must rebuild the input, and each digit must be 9 or less.
    for (int i = 0; i < 256; i++) begin
      in_binary = i[7:0];
      @(negedge clk);
      sum = int'(hundreds_bcd) * 100 + int'(packed_bcd[7:4]) * 10 + int'(packed_bcd[3:0]);
      chk("exh.sum", sum, i);
      chk("exh.tens_le9", {31'h0, (packed_bcd[7:4] <= 4'd9)}, 32'h1);
      chk("exh.ones_le9", {31'h0, (packed_bcd[3:0] <= 4'd9)}, 32'h1);
      chk("exh.unpacked", {16'h0, unpacked_bcd}, {16'h0, ref_unpacked(i)});
    end

    // Random values compared against the reference model.
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(255, 0));
      in_binary = r[7:0];
      @(negedge clk);
      check_all("rand", r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
